// File: rtl/gate_identifier.sv
// Sweeps the four input vectors of an attached two-input gate, captures its truth
// table and classifies it; result and match against a requested code held until next start.
module gate_identifier #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  input  logic [2:0] expected_code,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       valid,
  output logic       match
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_truth;
  logic [2:0] r_code;
  logic [2:0] r_exp;
  logic       r_valid;
  logic       r_match;

  logic       w_accept;
  logic       w_sample;
  logic       w_last_vec;
  logic [3:0] w_truth_nxt;
  logic [2:0] w_code_nxt;

  function automatic logic [2:0] classify(input logic [3:0] t);
    logic [2:0] c;
    case (t)
      4'b1000:          c = 3'd0;
      4'b1110:          c = 3'd1;
      4'b0111:          c = 3'd2;
      4'b0001:          c = 3'd3;
      4'b0110:          c = 3'd4;
      4'b1001:          c = 3'd5;
      4'b0000, 4'b1111: c = 3'd6;
      default:          c = 3'd7;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == LP_LAST) begin
          w_sample = 1'b1;
          if (r_idx == 2'd3) begin
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The final vector's bit must be folded in before classifying, so the code
  // and match are ready in the same cycle DONE is entered.
  assign w_last_vec = w_sample && (r_idx == 2'd3);

  always_comb begin
    w_truth_nxt = r_truth;
    if (w_sample) begin
      w_truth_nxt[r_idx] = gate_out;
    end
  end

  assign w_code_nxt = classify(w_truth_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_truth <= 4'd0;
      r_code  <= 3'd0;
      r_exp   <= 3'd0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_exp   <= expected_code;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else if (r_state == DRIVE) begin
      if (w_sample) begin
        r_cnt   <= 4'd0;
        r_truth <= w_truth_nxt;
        if (w_last_vec) begin
          r_code  <= w_code_nxt;
          r_valid <= 1'b1;
          r_match <= (w_code_nxt == r_exp);
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Decoded from the state register so reset clears them without a clock.
  assign gate_a    = (r_state == DRIVE) && r_idx[0];
  assign gate_b    = (r_state == DRIVE) && r_idx[1];
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign truth     = r_truth;
  assign gate_code = r_code;
  assign valid     = r_valid;
  assign match     = r_match;

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier: two instances (settle 2 and 1) against a behavioural model.
module tb_gate_identifier;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v    [2];
  logic [2:0] exp_code_v [2];
  int         sel        [2];
  logic       gout_v     [2];
  logic       ga_v       [2];
  logic       gb_v       [2];
  logic       busy_v     [2];
  logic       done_v     [2];
  logic [3:0] truth_v    [2];
  logic [2:0] code_v     [2];
  logic       valid_v    [2];
  logic       match_v    [2];

  int checks = 0;
  int errors = 0;

  // model state: mt = edges since accept, -1 when idle
  int         mt     [2] = '{-1, -1};
  logic [3:0] mtruth [2] = '{4'd0, 4'd0};
  logic [2:0] mcode  [2] = '{3'd0, 3'd0};
  logic [2:0] mcap   [2] = '{3'd0, 3'd0};
  logic       mvalid [2] = '{1'b0, 1'b0};
  logic       mmatch [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  // gate models: 0 AND 1 OR 2 NAND 3 NOR 4 XOR 5 XNOR 6 const1 7 buffer-of-a 8 const0
  function automatic logic gate_fn(input int s, input logic a, input logic b);
    case (s)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return 1'b1;
      7: return a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ref_code(input logic [3:0] t);
    logic [3:0] pats [6] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
    for (int k = 0; k < 6; k++) begin
      if (t == pats[k]) return 3'(k);
    end
    if (t == 4'b0000 || t == 4'b1111) return 3'd6;
    return 3'd7;
  endfunction

  function automatic int s_of(input int u);
    return (u == 0) ? S0 : S1;
  endfunction

  assign gout_v[0] = gate_fn(sel[0], ga_v[0], gb_v[0]);
  assign gout_v[1] = gate_fn(sel[1], ga_v[1], gb_v[1]);

  gate_identifier #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_out(gout_v[0]),
    .expected_code(exp_code_v[0]), .gate_a(ga_v[0]), .gate_b(gb_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .truth(truth_v[0]), .gate_code(code_v[0]),
    .valid(valid_v[0]), .match(match_v[0])
  );

  gate_identifier #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_out(gout_v[1]),
    .expected_code(exp_code_v[1]), .gate_a(ga_v[1]), .gate_b(gb_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .truth(truth_v[1]), .gate_code(code_v[1]),
    .valid(valid_v[1]), .match(match_v[1])
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mt[u] = -1; mtruth[u] = 4'd0; mcode[u] = 3'd0;
        mvalid[u] = 1'b0; mmatch[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (mt[u] < 0) begin
          if (start_v[u]) begin
            mt[u] = 0; mcap[u] = exp_code_v[u]; mvalid[u] = 1'b0; mmatch[u] = 1'b0;
          end
        end else begin
          mt[u] = mt[u] + 1;
          for (int i = 0; i < 4; i++) begin
            if (mt[u] == (i + 1) * s_of(u)) mtruth[u][i] = gate_fn(sel[u], i[0], i[1]);
          end
          if (mt[u] == 4 * s_of(u)) begin
            mcode[u] = ref_code(mtruth[u]); mvalid[u] = 1'b1; mmatch[u] = (mcode[u] == mcap[u]);
          end else if (mt[u] == 4 * s_of(u) + 1) begin
            mt[u] = -1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, u, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    int drv, idx, s;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int u = 0; u < 2; u++) begin
          s   = s_of(u);
          drv = (mt[u] >= 0 && mt[u] < 4 * s) ? 1 : 0;
          idx = (drv != 0) ? mt[u] / s : 0;
          chk("busy",   u, int'(busy_v[u]),  (mt[u] >= 0) ? 1 : 0);
          chk("done",   u, int'(done_v[u]),  (mt[u] == 4 * s) ? 1 : 0);
          chk("gate_a", u, int'(ga_v[u]),    (drv != 0) ? idx % 2 : 0);
          chk("gate_b", u, int'(gb_v[u]),    (drv != 0) ? idx / 2 : 0);
          chk("truth",  u, int'(truth_v[u]), int'(mtruth[u]));
          chk("code",   u, int'(code_v[u]),  int'(mcode[u]));
          chk("valid",  u, int'(valid_v[u]), int'(mvalid[u]));
          chk("match",  u, int'(match_v[u]), int'(mmatch[u]));
        end
      end
    end
  endtask

  task automatic chk_reset(input int u);
    chk("rst_busy",  u, int'(busy_v[u]),  0);
    chk("rst_done",  u, int'(done_v[u]),  0);
    chk("rst_a",     u, int'(ga_v[u]),    0);
    chk("rst_b",     u, int'(gb_v[u]),    0);
    chk("rst_truth", u, int'(truth_v[u]), 0);
    chk("rst_code",  u, int'(code_v[u]),  0);
    chk("rst_valid", u, int'(valid_v[u]), 0);
    chk("rst_match", u, int'(match_v[u]), 0);
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while (busy_v[u] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", u, int'(busy_v[u]), 0);
  endtask

  task automatic go(input int u);
    wait_idle(u);
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int n);
    n = 0;
    while (!done_v[u] && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic run_gate(input int u, input int s, input logic [2:0] code,
                          input logic [3:0] et, input logic [2:0] ec, input logic em);
    int n;
    sel[u] = s;
    exp_code_v[u] = code;
    go(u);
    wait_done(u, n);
    chk("latency",   u, n, 4 * s_of(u));
    chk("lit_truth", u, int'(truth_v[u]), int'(et));
    chk("lit_code",  u, int'(code_v[u]),  int'(ec));
    chk("lit_match", u, int'(match_v[u]), int'(em));
    chk("lit_valid", u, int'(valid_v[u]), 1);
  endtask

  initial begin
    logic [1:0] exp_seq [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
    int n, dn;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0; exp_code_v[u] = 3'd0; sel[u] = 0;
    end
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;

    // start right after reset release; accepted on the first edge
    run_gate(0, 0, 3'd0, 4'b1000, 3'd0, 1'b1);
    run_gate(0, 4, 3'd5, 4'b0110, 3'd4, 1'b0);
    run_gate(0, 6, 3'd6, 4'b1111, 3'd6, 1'b1);
    run_gate(0, 7, 3'd0, 4'b1010, 3'd7, 1'b0);
    run_gate(1, 3, 3'd3, 4'b0001, 3'd3, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("hold_truth", 0, int'(truth_v[0]), 4'b1010);
    chk("hold_valid", 0, int'(valid_v[0]), 1);

    // start re-pulsed mid-run is ignored
    sel[0] = 0;
    exp_code_v[0] = 3'd0;
    go(0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vec%0d", k), 0, int'({ga_v[0], gb_v[0]}), int'(exp_seq[k]));
      start_v[0] = (k == 3 || k == 5);
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    chk("single_done", 0, int'(done_v[0]), 1);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      dn += int'(done_v[0]);
    end
    chk("no_restart", 0, dn, 0);

    // start held high: one idle cycle between runs
    wait_idle(0);
    sel[0] = 2;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, n);
    chk("held_lat", 0, n, 4 * S0);
    @(posedge clk); #1;
    chk("held_idle", 0, int'(busy_v[0]), 0);
    @(posedge clk); #1;
    chk("held_restart", 0, int'(busy_v[0]), 1);
    start_v[0] = 1'b0;
    wait_done(0, n);
    chk("held_truth", 0, int'(truth_v[0]), 4'b0111);

    // reset mid-run aborts asynchronously
    sel[0] = 4;
    go(0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      dn += int'(done_v[0]) + int'(done_v[1]);
    end
    chk("no_done_after_rst", 0, dn, 0);
    run_gate(0, 1, 3'd1, 4'b1110, 3'd1, 1'b1);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int u = 0; u < 2; u++) begin
        start_v[u] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) sel[u] = int'($urandom_range(0, 8));
        exp_code_v[u] = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
